stage_sequencer: RTL
====================

Name: stage_sequencer

Overview:
- Generates the per-layer stage/step schedule for the output shift-register path.
- Drives rd_stage, wr_stage and rd_lstep into the SHRout control logic and the matching write-side controls.
- Steps through NUM_STAGES stages of a programmable number of steps each; the write side trails the read side by WR_LAT cycles.
- Started by a one-cycle start pulse; reports completion with a one-cycle done pulse.

Parameters:
- NUM_STAGES, 12, number of stages per layer (stages 0..NUM_STAGES-1); must be ≤16.
- STEP_W, 8, width of the step counter and of cfg_steps.
- WR_LAT, 2, read-to-write pipeline latency in cycles; must be ≥1.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle start request; sampled only in IDLE.
- cfg_steps  input  STEP_W  steps per stage; latched on accepted start.
- stall  input  1  freezes the whole schedule while high.
- rd_stage  output  4  current read stage.
- rd_lstep  output  1  high on the last read step of the current stage.
- rd_valid  output  1  a read step is issued this cycle.
- wr_stage  output  4  rd_stage delayed WR_LAT advancing cycles.
- wr_lstep  output  1  rd_lstep delayed WR_LAT advancing cycles.
- wr_valid  output  1  rd_valid delayed WR_LAT advancing cycles.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse at end of drain.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset:
  - FSM goes to IDLE.
  - Step and stage counters cleared; latched steps cleared.
  - Delay line cleared.
  - All outputs 0, including rd_stage and wr_stage.
  - Reset mid-RUN/DRAIN aborts immediately with no done pulse.
- States:
  - IDLE -> RUN on start. Latch last_step = max(cfg_steps,1)-1 (cfg_steps=0 is treated as 1). stage=0, step=0.
  - RUN: rd_valid=1 unless stall.
    - rd_lstep = rd_valid && (step==last_step).
    - Each non-stalled cycle, step increments.
    - On rd_lstep, step returns to 0 and stage increments.
    - When rd_lstep occurs with stage==NUM_STAGES-1, go to DRAIN and hold rd_stage at NUM_STAGES-1.
  - DRAIN: rd_valid=0, rd_lstep=0. Counts WR_LAT non-stalled cycles, then goes to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then -> IDLE.
- Signal rules:
  - rd_stage/rd_lstep/rd_valid are combinational from registered state. The rd_lstep gating by rd_valid is mandatory: SHRout reset decoding uses rd_lstep.
  - busy is 1 in RUN and DRAIN only.
- Delay line:
  - WR_LAT-deep register chain carrying {rd_valid, rd_lstep, rd_stage}; shifts only when stall=0.
  - wr_* are the chain outputs.
  - While stalled, wr_* hold their values, but wr_valid is forced to 0 for that cycle.
- Stall:
  - Freezes the counters, the FSM and the delay line in every state except IDLE and DONE.
  - DONE always completes in one cycle.
- Other boundary rules:
  - start while busy is ignored.
  - start in the DONE cycle is ignored.
  - start and rst together: rst wins.
  - cfg_steps changes after start have no effect.
  - Total read steps per layer = NUM_STAGES*(last_step+1).
  - done occurs exactly WR_LAT advancing cycles after the final rd_lstep, plus one cycle.

Decomposition:
- Shared package (stage_pkg):
  - FSM state encoding (IDLE, RUN, DRAIN, DONE).
  - STAGE_W=4.
  - Named stage constants used by the SHRout decoding: STG_SYS_A=1, STG_SYS_B=3, STG_KEEP_A=0, STG_KEEP_B=2.
- Sub-module: stage_delay_line, a parameterised DEPTH×WIDTH shift chain with an enable and synchronous clear. It is reused for the wr_* path.

Test Plan:
- Basic run: NUM_STAGES=12, WR_LAT=2, cfg_steps=3, start.
  - rd_valid high 36 cycles; rd_lstep pulses at cycles 3,6,…,36; rd_stage 0→11.
  - wr_* equal rd_* shifted by 2.
  - done pulses 3 cycles after the final rd_lstep; busy low after.
- Degenerate config: cfg_steps=0 and cfg_steps=1.
  - rd_lstep high on every rd_valid cycle; stage advances every cycle; 12 valid cycles.
- Stall: stall 4 cycles mid stage 5 (cfg_steps=4, step=2).
  - Counters and wr_* hold; rd_valid and wr_valid are 0 during the stall.
  - Sequence resumes at step 2; done delayed by exactly 4 cycles.
- Reset: rst asserted during stage 7 (and again in DRAIN).
  - All outputs 0 next cycle, no done pulse.
  - A new start runs cleanly from stage 0.
- Ignored starts: start asserted during RUN and in the DONE cycle, with cfg_steps changed to 9.
  - No restart; the original last_step is kept; exactly one done.
- Latch timing: cfg_steps=5 at start, changed to 2 one cycle later.
  - Each stage still has 5 steps.

Source files
------------

// File: rtl/stage_pkg.sv
// Shared definitions for the per-layer stage/step scheduler.
package stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int STAGE_W = 4;

  // Stage numbers the SHRout control decodes specially.
  localparam logic [STAGE_W-1:0] STG_KEEP_A = 4'd0;
  localparam logic [STAGE_W-1:0] STG_SYS_A  = 4'd1;
  localparam logic [STAGE_W-1:0] STG_KEEP_B = 4'd2;
  localparam logic [STAGE_W-1:0] STG_SYS_B  = 4'd3;

endpackage

// File: rtl/stage_delay_line.sv
// DEPTH x WIDTH shift chain with enable and synchronous clear.
module stage_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_tap
      logic [WIDTH-1:0] tap_reg;
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst)     tap_reg <= '0;
          else if (en) tap_reg <= d;
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (rst)     tap_reg <= '0;
          else if (en) tap_reg <= g_tap[gi-1].tap_reg;
        end
      end
    end
  endgenerate

  assign q = g_tap[DEPTH-1].tap_reg;

endmodule

// File: rtl/stage_sequencer.sv
// Per-layer stage/step schedule for the output shift-register path; the
// write-side controls trail the read side by WR_LAT advancing cycles.
module stage_sequencer
  import stage_pkg::*;
#(
  parameter int NUM_STAGES = 12,
  parameter int STEP_W     = 8,
  parameter int WR_LAT     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STEP_W-1:0]  cfg_steps,
  input  logic               stall,
  output logic [STAGE_W-1:0] rd_stage,
  output logic               rd_lstep,
  output logic               rd_valid,
  output logic [STAGE_W-1:0] wr_stage,
  output logic               wr_lstep,
  output logic               wr_valid,
  output logic               busy,
  output logic               done
);

  localparam int DRAIN_W = $clog2(WR_LAT) + 1;
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(WR_LAT - 1);
  localparam int LINE_W = STAGE_W + 2;

  state_t              state_reg, state_next;
  logic [STEP_W-1:0]   step_reg, step_next;
  logic [STEP_W-1:0]   last_step_reg, last_step_next;
  logic [STAGE_W-1:0]  stage_reg, stage_next;
  logic [DRAIN_W-1:0]  drain_reg, drain_next;
  logic                line_en;
  logic [LINE_W-1:0]   line_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      step_reg      <= '0;
      last_step_reg <= '0;
      stage_reg     <= '0;
      drain_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      step_reg      <= step_next;
      last_step_reg <= last_step_next;
      stage_reg     <= stage_next;
      drain_reg     <= drain_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    step_next      = step_reg;
    last_step_next = last_step_reg;
    stage_next     = stage_reg;
    drain_next     = drain_reg;
    rd_valid       = 1'b0;
    rd_lstep       = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    line_en        = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
          step_next  = '0;
          stage_next = '0;
          // A zero step count still issues one step per stage.
          last_step_next = (cfg_steps == '0) ? '0 : cfg_steps - 1'b1;
        end
      end
      ST_RUN: begin
        busy     = 1'b1;
        line_en  = !stall;
        rd_valid = !stall;
        rd_lstep = rd_valid && (step_reg == last_step_reg);
        if (rd_valid) begin
          if (rd_lstep) begin
            step_next = '0;
            if (stage_reg == LAST_STAGE) begin
              state_next = ST_DRAIN;
              drain_next = '0;
            end else begin
              stage_next = stage_reg + 1'b1;
            end
          end else begin
            step_next = step_reg + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        busy    = 1'b1;
        line_en = !stall;
        if (!stall) begin
          if (drain_reg == LAST_DRAIN) state_next = ST_DONE;
          else                         drain_next = drain_reg + 1'b1;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign rd_stage = stage_reg;

  stage_delay_line #(
    .DEPTH(WR_LAT),
    .WIDTH(LINE_W)
  ) u_wr_line (
    .clk(clk),
    .rst(rst),
    .en (line_en),
    .d  ({rd_valid, rd_lstep, rd_stage}),
    .q  (line_q)
  );

  // The write side holds while stalled but must not issue a step.
  assign wr_valid = line_q[LINE_W-1] && !stall;
  assign wr_lstep = line_q[LINE_W-2];
  assign wr_stage = line_q[STAGE_W-1:0];

endmodule
